// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit path.
// The optional parity state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

  localparam int   CLK_DIV_DEFAULT   = 5208;
  localparam int   DATA_BITS_DEFAULT = 8;
  localparam logic LINE_IDLE         = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLK_DIV-1 and flags the last cycle of each bit.
// A synchronous clear holds the count at zero so each frame aligns to its start bit.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_end
);

  localparam int               CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    bit_end = (cnt_q == CNT_LAST);
    cnt_d   = cnt_q + CNT_W'(1);
    if (clr || bit_end) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one byte per valid/ready handshake, sent start/data(LSB first)/stop.
// Defining UART_TX_PARITY_EN inserts an even-parity bit between data and stop.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_DIV   = CLK_DIV_DEFAULT,
  parameter int DATA_BITS = DATA_BITS_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 miso,
  output logic                 tx_busy,
  output logic                 tx_done
);

  // Handshake: a byte is taken on any clock edge where tx_valid && tx_ready;
  // tx_ready is high only in IDLE, so tx_valid while busy has no effect.

  localparam int             IDX_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 miso_q, miso_d;
  logic                 bit_end;
  logic                 baud_clr;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  // The counter is parked at zero whenever idle, which also clears it on accept.
  assign baud_clr = (state_q == ST_IDLE);

  uart_baud_cnt #(
    .CLK_DIV (CLK_DIV)
  ) u_baud_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (baud_clr),
    .bit_end (bit_end)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    tx_done = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (tx_valid) begin
          shift_d = tx_data;
          idx_d   = '0;
          state_d = ST_START;
`ifdef UART_TX_PARITY_EN
          parity_d = ^tx_data;
`endif
        end
      end
      ST_START: begin
        if (bit_end) begin
          idx_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          tx_done = !rst;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // The line is registered from the next state so it changes with the state.
    case (state_d)
      ST_START: miso_d = 1'b0;
      ST_DATA:  miso_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: miso_d = parity_d;
`endif
      default:  miso_d = LINE_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      miso_q  <= LINE_IDLE;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      miso_q  <= miso_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign miso     = miso_q;
  assign tx_ready = (state_q == ST_IDLE);
  assign tx_busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx at CLK_DIV=4 with randomized bytes and a frame-level model.
// Build with UART_TX_PARITY_EN defined to exercise the 11-bit frame.
module tb_uart_tx;

  localparam int CD = 4;
  localparam int DW = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME_CYC = NB * CD;

  logic          clk = 1'b0;
  logic          rst;
  logic          tx_valid;
  logic [DW-1:0] tx_data;
  logic          tx_ready;
  logic          miso;
  logic          tx_busy;
  logic          tx_done;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int accept_cyc   = 0;

  logic [0:0] exp_q[$];

  uart_tx #(
    .CLK_DIV   (CD),
    .DATA_BITS (DW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .miso     (miso),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  // Clock and reset
  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: sim time limit reached, tests_failed=%0d", tests_failed);
    $fatal(1, "watchdog");
  end

  // Reference model: the line level for every cycle of the frame carrying d.
  function automatic void load_frame(input logic [DW-1:0] d);
    logic [0:0] lv;
    exp_q.delete();
    for (int b = 0; b < NB; b++) begin
      if (b == 0) lv = 1'b0;
      else if (b <= DW) lv = d[b-1];
`ifdef UART_TX_PARITY_EN
      else if (b == DW + 1) lv = (($countones(d) % 2) == 1);
`endif
      else lv = 1'b1;
      repeat (CD) exp_q.push_back(lv);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Driver: waits for ready, presents d, then checks cycles 1..limit after the accept.
  task automatic send_frame(input logic [DW-1:0] d, input logic hold, input logic [DW-1:0] after_d,
                            input int pulse_cyc, input int limit, input string name);
    logic [0:0] e;
    logic       want_done;
    int         w;
    w = 0;
    while (tx_ready !== 1'b1 && w < 4 * FRAME_CYC) begin
      step();
      w++;
    end
    tests_run++;
    if (tx_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s ready_wait: tx_ready=%b want 1", name, tx_ready);
    end
    tx_data  = d;
    tx_valid = 1'b1;
    step();
    accept_cyc = cyc;
    tx_valid   = hold;
    tx_data    = after_d;
    load_frame(d);
    for (int k = 1; k <= limit; k++) begin
      e         = exp_q.pop_front();
      want_done = (k == FRAME_CYC);
      tests_run++;
      if (miso !== e || tx_done !== want_done || tx_busy !== 1'b1 || tx_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL %s cycle %0d: miso=%b done=%b busy=%b ready=%b want miso=%b done=%b busy=1 ready=0",
                 name, k, miso, tx_done, tx_busy, tx_ready, e, want_done);
      end
      if (k == pulse_cyc) begin
        tx_valid = 1'b1;
        tx_data  = 8'h3C;
      end else if (k == pulse_cyc + 1) begin
        tx_valid = hold;
        tx_data  = after_d;
      end
      step();
    end
    if (limit == FRAME_CYC) begin
      tests_run++;
      if (tx_ready !== 1'b1 || miso !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
        tests_failed++;
        $display("FAIL %s end: ready=%b miso=%b busy=%b done=%b want 1 1 0 0",
                 name, tx_ready, miso, tx_busy, tx_done);
      end
    end
  endtask

  task automatic check_idle(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      tests_run++;
      if (miso !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
        tests_failed++;
        $display("FAIL %s idle %0d: miso=%b ready=%b busy=%b done=%b want 1 1 0 0",
                 name, i, miso, tx_ready, tx_busy, tx_done);
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle(20, "reset");
  endtask

  task automatic test_a5();
    send_frame(8'hA5, 1'b0, 8'($urandom_range(0, 255)), 0, FRAME_CYC, "a5");
    check_idle(3, "a5_after");
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      send_frame(8'($urandom_range(0, 255)), 1'b0, 8'($urandom_range(0, 255)), 0, FRAME_CYC, "random");
      repeat ($urandom_range(0, 3)) step();
    end
  endtask

  task automatic test_back_to_back();
    int a1;
    send_frame(8'h00, 1'b1, 8'hFF, 0, FRAME_CYC, "b2b_first");
    a1 = accept_cyc;
    send_frame(8'hFF, 1'b0, 8'($urandom_range(0, 255)), 0, FRAME_CYC, "b2b_second");
    tests_run++;
    if (accept_cyc - a1 !== FRAME_CYC + 1) begin
      tests_failed++;
      $display("FAIL b2b_period: got %0d want %0d", accept_cyc - a1, FRAME_CYC + 1);
    end
  endtask

  task automatic test_ignore_valid();
    send_frame(8'($urandom_range(0, 255)), 1'b0, 8'($urandom_range(0, 255)), 10, FRAME_CYC, "ignore");
    check_idle(20, "ignore_after");
  endtask

  task automatic test_reset_mid_frame();
    logic [0:0] e;
    send_frame(8'h55, 1'b0, 8'($urandom_range(0, 255)), 0, 16, "rst_mid");
    e = exp_q.pop_front();
    tests_run++;
    if (miso !== e || tx_done !== 1'b0 || tx_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_mid cycle 17: miso=%b done=%b busy=%b want miso=%b done=0 busy=1",
               miso, tx_done, tx_busy, e);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    check_idle(6, "rst_mid_after");
    send_frame(8'h81, 1'b0, 8'($urandom_range(0, 255)), 0, FRAME_CYC, "after_rst_81");
  endtask

  task automatic test_reset_with_valid();
    rst      = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 8'hC3;
    step();
    rst      = 1'b0;
    tx_valid = 1'b0;
    check_idle(4, "rst_valid");
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    send_frame(8'hA5, 1'b0, 8'($urandom_range(0, 255)), 0, FRAME_CYC, "parity_a5");
    send_frame(8'h01, 1'b0, 8'($urandom_range(0, 255)), 0, FRAME_CYC, "parity_01");
  endtask
`endif

  initial begin
    test_reset();
    test_a5();
    test_random();
    test_back_to_back();
    test_ignore_valid();
    test_reset_mid_frame();
    test_reset_with_valid();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
